// File: rtl/jtframe_sdram_pkg.sv
// Shared constants for the frame SDRAM bank arbiters: FSM encoding, handshake widths and the
// grant-index width helper.
package jtframe_sdram_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t StIdle = 2'd0;
    localparam arb_state_t StReq  = 2'd1;
    localparam arb_state_t StWait = 2'd2;

    localparam int unsigned BaDinW     = 16;
    localparam int unsigned BaMaskW    = 2;
    localparam int unsigned SdramDoutW = 32;

    // $clog2(clients), never narrower than one bit
    function automatic int unsigned gnt_w(int unsigned clients);
        return (clients > 1) ? $clog2(clients) : 1;
    endfunction

endpackage

// File: rtl/jtframe_rr_pick.sv
// Combinational grant picker: round-robin starting after the last grant, or fixed priority
// (lowest index) when rr is low.
module jtframe_rr_pick #(
    parameter int unsigned CLIENTS = 4,
    parameter int unsigned IW      = 2
) (
    input  logic [CLIENTS-1:0] pend,
    input  logic [IW-1:0]      last,
    input  logic               rr,
    output logic [CLIENTS-1:0] gnt_oh,
    output logic [IW-1:0]      gnt_idx
);

    logic [IW-1:0] idx;
    logic          found;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < CLIENTS; k++) begin
            idx = rr ? IW'((32'(last) + 32'd1 + k) % CLIENTS) : IW'(k);
            if (!found && pend[idx]) begin
                found        = 1'b1;
                gnt_idx      = idx;
                gnt_oh[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jtframe_bank_arb.sv
// Shares one SDRAM bank port among CLIENTS requesters. Transactions always run to completion;
// a client that drops or moves its request mid-flight simply gets no result.
module jtframe_bank_arb
    import jtframe_sdram_pkg::*;
#(
    parameter int unsigned CLIENTS = 4,
    parameter int unsigned AW      = 22,
    parameter int unsigned DW      = 16,
    parameter bit          RR      = 1'b1
) (
    input  logic                         rst,
    input  logic                         clk,
    input  logic [CLIENTS*AW-1:0]        cl_addr,
    input  logic [CLIENTS-1:0]           cl_rd,
    input  logic [CLIENTS-1:0]           cl_wr,
    input  logic [CLIENTS*BaDinW-1:0]    cl_din,
    input  logic [CLIENTS*BaMaskW-1:0]   cl_din_m,
    output logic [CLIENTS*DW-1:0]        cl_dout,
    output logic [CLIENTS-1:0]           cl_ok,
    output logic [AW-1:0]                ba_addr,
    output logic                         ba_rd,
    output logic                         ba_wr,
    output logic [BaDinW-1:0]            ba_din,
    output logic [BaMaskW-1:0]           ba_din_m,
    input  logic                         ba_ack,
    input  logic                         ba_rdy,
    input  logic [SdramDoutW-1:0]        sdram_dout
);

    localparam int unsigned IW = gnt_w(CLIENTS);

    logic [AW-1:0]      addr_a     [CLIENTS];
    logic [BaDinW-1:0]  din_a      [CLIENTS];
    logic [BaMaskW-1:0] mask_a     [CLIENTS];
    logic [AW-1:0]      srv_addr_q [CLIENTS];
    logic [DW-1:0]      dout_q     [CLIENTS];

    logic [CLIENTS-1:0] req, pend, clr, gnt_oh;
    logic [IW-1:0]      gnt_idx, gnt_q, last_q;
    arb_state_t         st_q;
    logic               wr_q, drop_q, drop_now, done, keep;
    logic               unused_dout;

    assign unused_dout = ^sdram_dout;

    for (genvar i = 0; i < CLIENTS; i++) begin : g_cl
        assign addr_a[i]             = cl_addr[i*AW +: AW];
        assign din_a[i]              = cl_din[i*BaDinW +: BaDinW];
        assign mask_a[i]             = cl_din_m[i*BaMaskW +: BaMaskW];
        assign cl_dout[i*DW +: DW]   = dout_q[i];
        assign clr[i]                = ~req[i] | (addr_a[i] != srv_addr_q[i]);
    end

    assign req  = cl_rd | cl_wr;
    assign pend = req & ~cl_ok;

    // The granted client walked away from the in-flight transaction
    assign drop_now = ~req[gnt_q] | (addr_a[gnt_q] != ba_addr);
    assign done     = ba_rdy & (((st_q == StReq) & ba_ack) | (st_q == StWait));
    assign keep     = done & ~drop_q & ~drop_now;

    jtframe_rr_pick #(
        .CLIENTS (CLIENTS),
        .IW      (IW)
    ) u_pick (
        .pend    (pend),
        .last    (last_q),
        .rr      (RR),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q     <= StIdle;
            gnt_q    <= '0;
            last_q   <= IW'(CLIENTS - 1);
            wr_q     <= 1'b0;
            drop_q   <= 1'b0;
            ba_addr  <= '0;
            ba_rd    <= 1'b0;
            ba_wr    <= 1'b0;
            ba_din   <= '0;
            ba_din_m <= '0;
            cl_ok    <= '0;
            for (int i = 0; i < CLIENTS; i++) begin
                srv_addr_q[i] <= '0;
                dout_q[i]     <= '0;
            end
        end else begin
            for (int i = 0; i < CLIENTS; i++) begin
                if (keep && gnt_q == IW'(i)) begin
                    cl_ok[i]      <= 1'b1;
                    srv_addr_q[i] <= ba_addr;
                    if (!wr_q) dout_q[i] <= sdram_dout[DW-1:0];
                end else if (clr[i]) begin
                    cl_ok[i] <= 1'b0;
                end
            end

            unique case (st_q)
                StIdle: begin
                    if (|gnt_oh) begin
                        st_q     <= StReq;
                        gnt_q    <= gnt_idx;
                        last_q   <= gnt_idx;
                        drop_q   <= 1'b0;
                        wr_q     <= cl_wr[gnt_idx];
                        ba_wr    <= cl_wr[gnt_idx];
                        ba_rd    <= ~cl_wr[gnt_idx];
                        ba_addr  <= addr_a[gnt_idx];
                        ba_din   <= din_a[gnt_idx];
                        ba_din_m <= mask_a[gnt_idx];
                    end
                end
                StReq: begin
                    if (drop_now) drop_q <= 1'b1;
                    if (ba_ack) begin
                        ba_rd <= 1'b0;
                        ba_wr <= 1'b0;
                        st_q  <= ba_rdy ? StIdle : StWait;
                    end
                end
                StWait: begin
                    if (drop_now) drop_q <= 1'b1;
                    if (ba_rdy) st_q <= StIdle;
                end
                default: st_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_jtframe_bank_arb.sv
// Directed bench: a round-robin 16-bit instance and a fixed-priority 32-bit instance share all
// client and controller stimulus, so both run the same handshake timeline.
module tb_jtframe_bank_arb;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 22;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]    cl_rd, cl_wr;
    logic [AW-1:0]   addr [N];
    logic [15:0]     din  [N];
    logic [1:0]      mask [N];
    logic [N*AW-1:0] cl_addr;
    logic [N*16-1:0] cl_din;
    logic [N*2-1:0]  cl_din_m;
    logic            ba_ack, ba_rdy;
    logic [31:0]     sdram_dout;

    logic [N*16-1:0] d0_dout;
    logic [N-1:0]    d0_ok;
    logic [AW-1:0]   d0_addr;
    logic            d0_rd, d0_wr;
    logic [15:0]     d0_din;
    logic [1:0]      d0_m;

    logic [N*32-1:0] d1_dout;
    logic [N-1:0]    d1_ok;
    logic [AW-1:0]   d1_addr;
    logic            d1_rd, d1_wr;
    logic [15:0]     d1_din;
    logic [1:0]      d1_m;

    int n_chk  = 0;
    int n_fail = 0;

    always_comb begin
        cl_addr  = '0;
        cl_din   = '0;
        cl_din_m = '0;
        for (int i = 0; i < N; i++) begin
            cl_addr[i*AW +: AW] = addr[i];
            cl_din[i*16 +: 16]  = din[i];
            cl_din_m[i*2 +: 2]  = mask[i];
        end
    end

    jtframe_bank_arb #(.CLIENTS(N), .AW(AW), .DW(16), .RR(1'b1)) u_rr (
        .rst(rst), .clk(clk), .cl_addr(cl_addr), .cl_rd(cl_rd), .cl_wr(cl_wr),
        .cl_din(cl_din), .cl_din_m(cl_din_m), .cl_dout(d0_dout), .cl_ok(d0_ok),
        .ba_addr(d0_addr), .ba_rd(d0_rd), .ba_wr(d0_wr), .ba_din(d0_din), .ba_din_m(d0_m),
        .ba_ack(ba_ack), .ba_rdy(ba_rdy), .sdram_dout(sdram_dout)
    );

    jtframe_bank_arb #(.CLIENTS(N), .AW(AW), .DW(32), .RR(1'b0)) u_fix (
        .rst(rst), .clk(clk), .cl_addr(cl_addr), .cl_rd(cl_rd), .cl_wr(cl_wr),
        .cl_din(cl_din), .cl_din_m(cl_din_m), .cl_dout(d1_dout), .cl_ok(d1_ok),
        .ba_addr(d1_addr), .ba_rd(d1_rd), .ba_wr(d1_wr), .ba_din(d1_din), .ba_din_m(d1_m),
        .ba_ack(ba_ack), .ba_rdy(ba_rdy), .sdram_dout(sdram_dout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ack_rdy(input logic [31:0] data);
        ba_ack = 1'b1;
        tick;
        ba_ack     = 1'b0;
        ba_rdy     = 1'b1;
        sdram_dout = data;
        tick;
        ba_rdy = 1'b0;
    endtask

    initial begin
        cl_rd = '0; cl_wr = '0; ba_ack = 1'b0; ba_rdy = 1'b0; sdram_dout = '0;
        for (int i = 0; i < N; i++) begin
            addr[i] = '0; din[i] = '0; mask[i] = '0;
        end

        // Reset state
        #12;
        chk("reset rd/wr", {d0_rd, d0_wr, d1_rd, d1_wr}, 0);
        chk("reset ok", {d0_ok, d1_ok}, 0);
        chk("reset addr", {d0_addr, d1_addr}, 0);
        chk("reset dout", {d0_dout, d1_dout}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // All four read; RR rotates 0..3,0 while fixed priority keeps taking client 0
        for (int i = 0; i < N; i++) addr[i] = 22'h100 + 22'(i);
        cl_rd = 4'hF;
        for (int j = 0; j < 5; j++) begin
            tick;
            chk("rr grant addr", d0_addr, 22'h100 + 22'(j % 4));
            chk("fix grant addr", d1_addr, 22'h100);
            chk("grant rd", {d0_rd, d1_rd}, 2'b11);
            ack_rdy(32'h0000D000 + 32'(j));
            chk("rr ok", d0_ok, 4'b0001 << (j % 4));
            chk("fix ok", d1_ok, 4'b0001);
            chk("rr dout", d0_dout[(j % 4)*16 +: 16], 16'hD000 + 16'(j));
            cl_rd = '0;
            tick;
            if (j < 4) cl_rd = 4'hF;
        end

        // Single read, ack on the fourth request cycle, rdy one cycle later
        addr[1] = 22'h12345;
        cl_rd   = 4'b0010;
        tick;
        chk("read rd", {d0_rd, d1_rd}, 2'b11);
        chk("read addr", {d0_addr, d1_addr}, {22'h12345, 22'h12345});
        tick; tick; tick;
        chk("read rd held", {d0_rd, d1_rd}, 2'b11);
        ba_ack = 1'b1;
        tick;
        ba_ack = 1'b0;
        chk("read rd dropped", {d0_rd, d1_rd}, 2'b00);
        ba_rdy = 1'b1; sdram_dout = 32'h0000BEEF;
        tick;
        ba_rdy = 1'b0;
        chk("read dout16", d0_dout[31:16], 16'hBEEF);
        chk("read dout32", d1_dout[63:32], 32'h0000BEEF);
        chk("read ok", {d0_ok, d1_ok}, 8'b0010_0010);
        cl_rd = '0;
        tick;
        chk("read ok clear", {d0_ok, d1_ok}, 8'h00);
        chk("read idle", {d0_rd, d1_rd}, 2'b00);

        // Masked write; client data changes after grant but the bank side stays latched
        addr[2] = 22'h2222; din[2] = 16'hA55A; mask[2] = 2'b10;
        cl_wr   = 4'b0100;
        tick;
        chk("wr dir", {d0_wr, d0_rd, d1_wr, d1_rd}, 4'b1010);
        chk("wr din", {d0_din, d1_din}, {16'hA55A, 16'hA55A});
        chk("wr mask", {d0_m, d1_m}, 4'b1010);
        din[2] = 16'h1234; mask[2] = 2'b01;
        tick;
        chk("wr din held", {d0_din, d0_m, d0_wr}, {16'hA55A, 2'b10, 1'b1});
        ba_ack = 1'b1;
        tick;
        ba_ack = 1'b0;
        chk("wr dropped", {d0_wr, d1_wr}, 2'b00);
        ba_rdy = 1'b1; sdram_dout = 32'h11111111;
        tick;
        ba_rdy = 1'b0;
        chk("wr ok", {d0_ok, d1_ok}, 8'b0100_0100);
        chk("wr dout kept", {d0_dout[47:32], d1_dout[95:64]}, {16'hD002, 32'h0});
        cl_wr = '0;
        tick;

        // Client 0 moves its address during WAIT: result discarded, new address reissued
        addr[0] = 22'h3000;
        cl_rd   = 4'b0001;
        tick;
        chk("abandon addr", {d0_addr, d1_addr}, {22'h3000, 22'h3000});
        ba_ack = 1'b1;
        tick;
        ba_ack  = 1'b0;
        addr[0] = 22'h3004;
        tick;
        ba_rdy = 1'b1; sdram_dout = 32'h55555555;
        tick;
        ba_rdy = 1'b0;
        chk("abandon ok", {d0_ok, d1_ok}, 8'h00);
        chk("abandon dout", {d0_dout[15:0], d1_dout[31:0]}, {16'hD004, 32'h0000D004});
        tick;
        chk("reissue rd", {d0_rd, d1_rd}, 2'b11);
        chk("reissue addr", {d0_addr, d1_addr}, {22'h3004, 22'h3004});
        ack_rdy(32'h00006666);
        chk("reissue ok", {d0_ok, d1_ok}, 8'b0001_0001);
        chk("reissue dout", {d0_dout[15:0], d1_dout[31:0]}, {16'h6666, 32'h00006666});
        cl_rd = '0;
        tick;

        // Same-cycle ack and rdy at the top of the address range
        addr[3] = 22'h3FFFFF;
        cl_rd   = 4'b1000;
        tick;
        chk("fast addr", d1_addr, 22'h3FFFFF);
        ba_ack = 1'b1; ba_rdy = 1'b1; sdram_dout = 32'hCAFEF00D;
        tick;
        ba_ack = 1'b0; ba_rdy = 1'b0;
        chk("fast dout32", d1_dout[127:96], 32'hCAFEF00D);
        chk("fast dout16", d0_dout[63:48], 16'hF00D);
        chk("fast ok", {d0_ok, d1_ok}, 8'b1000_1000);
        chk("fast rd low", {d0_rd, d1_rd}, 2'b00);
        addr[2] = 22'h0ABC;
        cl_rd   = 4'b1100;
        tick;
        chk("next grant rd", {d0_rd, d1_rd}, 2'b11);
        chk("next grant addr", {d0_addr, d1_addr}, {22'h0ABC, 22'h0ABC});
        chk("ok held", {d0_ok, d1_ok}, 8'b1000_1000);

        // Asynchronous reset while in REQ
        #2 rst = 1'b1;
        #1;
        chk("async rst rd/wr", {d0_rd, d0_wr, d1_rd, d1_wr}, 0);
        chk("async rst addr", {d0_addr, d1_addr}, 0);
        chk("async rst din", {d0_din, d0_m, d1_din, d1_m}, 0);
        chk("async rst ok", {d0_ok, d1_ok}, 0);
        chk("async rst dout", {d0_dout, d1_dout}, 0);
        tick;
        rst     = 1'b0;
        addr[0] = 22'h0111;
        cl_rd   = 4'hF;
        tick;
        chk("post rst rd", {d0_rd, d1_rd}, 2'b11);
        chk("post rst grant", {d0_addr, d1_addr}, {22'h0111, 22'h0111});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/jtframe_bank_arb.md
# jtframe_bank_arb

Parametrised arbiter that shares one SDRAM bank port among `CLIENTS` requesters. It is the next generation of the fixed one-client-per-bank wiring between the game module and the frame's SDRAM controller. It adds per-bank multiplexing, round-robin or fixed priority, read and masked-write support on any client, and per-client latched read data. One instance sits in front of each of the controller's bank ports (`ba0`..`ba3`).

## Interface
Parameters:
- `CLIENTS`, 4: number of requesters, 2..8.
- `AW`, 22: SDRAM word address width (matches `SDRAMW`).
- `DW`, 16: client read-data width; 16 uses `sdram_dout[15:0]`, 32 uses all 32 bits.
- `RR`, 1: 1 = round-robin; 0 = fixed priority, lowest index wins.

Ports:
- `rst` in 1: asynchronous, active-high reset.
- `clk` in 1: single clock, the SDRAM/`clk_rom` domain.
- `cl_addr` in CLIENTS*AW: packed client addresses; client i uses bits [i*AW +: AW].
- `cl_rd` in CLIENTS: read request, level.
- `cl_wr` in CLIENTS: write request, level.
- `cl_din` in CLIENTS*16: write data.
- `cl_din_m` in CLIENTS*2: write byte mask, active-high = byte masked.
- `cl_dout` out CLIENTS*DW: per-client latched read data.
- `cl_ok` out CLIENTS: request served; data valid for reads.
- `ba_addr` out AW: bank address.
- `ba_rd` out 1: bank read request.
- `ba_wr` out 1: bank write request.
- `ba_din` out 16: bank write data.
- `ba_din_m` out 2: bank write mask.
- `ba_ack` in 1: bank accepted the request.
- `ba_rdy` in 1: transaction complete; `sdram_dout` valid this cycle.
- `sdram_dout` in 32: shared controller read data.

## Operation
- Pending(i) = (`cl_rd[i]` | `cl_wr[i]`) & ~`cl_ok[i]`. If both `cl_rd[i]` and `cl_wr[i]` are high, the request is a write.
- FSM states and transitions:
  - IDLE: if any client is pending, register grant g, its address, data, mask and direction, then go to REQ.
  - REQ: drive `ba_rd` or `ba_wr` with the latched fields. On `ba_ack`, drop the request and go to WAIT. If `ba_ack` and `ba_rdy` arrive in the same cycle, go straight to DONE handling.
  - WAIT: on `ba_rdy`, capture `sdram_dout[DW-1:0]` into `cl_dout[g]`, set `cl_ok[g]`, and go to IDLE.
- Grant selection:
  - RR=1: search starts at last grant + 1, modulo CLIENTS. The pointer resets to CLIENTS-1, so client 0 wins first.
  - RR=0: lowest pending index wins.
- `cl_ok[i]` clears on the first cycle in which both `cl_rd[i]` and `cl_wr[i]` are low, or in which `cl_addr[i]` differs from the address that was served.
- Bank transactions cannot be aborted:
  - If client g drops its request or changes address during REQ or WAIT, the transaction still completes.
  - The result is then discarded: `cl_dout[g]` is not updated and `cl_ok[g]` stays low.
  - A changed address is re-arbitrated as a new request.
- Reset (asynchronous, including mid-transaction): FSM goes to IDLE, and `ba_rd`, `ba_wr`, `ba_addr`, `ba_din`, `ba_din_m`, `cl_ok` and `cl_dout` all go to 0. The controller is reset by the same `rst`.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Pending seen at edge n → `ba_rd`/`ba_wr` high after edge n.
- `ba_ack` high at edge m → request low after edge m.
- `ba_rdy` at edge k → `cl_ok[g]` and `cl_dout[g]` valid after edge k. FSM is in IDLE after k, so the next grant's request is high after edge k+1.
- Arbiter overhead per transaction: 2 cycles beyond controller latency.
- `ba_addr` and `ba_din` are held stable from REQ entry until `ba_ack`.
- With RR=1, no client waits for more than CLIENTS-1 other transactions.

## Structure
- Package `jtframe_sdram_pkg`:
  - Arbiter state enum (IDLE, REQ, WAIT).
  - Grant index width constant `$clog2(CLIENTS)`.
  - Bank handshake field widths.
- Sub-module `jtframe_rr_pick`: purely combinational. Inputs are the pending vector, the last-grant pointer and the `RR` mode; outputs are a one-hot grant and its index. It is reused by other frame arbiters.

## Test plan
- Single read: client 1 reads 0x12345; controller acks 3 cycles later and gives rdy 5 cycles later with 0xBEEF. Expect `ba_rd` pulse width 4 cycles, `cl_dout[1]`=0xBEEF, `cl_ok[1]`=1 one cycle after rdy. Drop `cl_rd[1]` → `cl_ok[1]`=0 next cycle.
- Round-robin: all 4 clients hold reads. Grants must come in order 0,1,2,3,0. Repeat with RR=0 → client 0 is served again each time its `cl_ok` clears.
- Masked write: client 2 writes 0xA55A with mask 2'b10. Expect `ba_wr`=1, `ba_din`=0xA55A, `ba_din_m`=2'b10 until ack. Then `cl_ok[2]`=1, and `cl_dout[2]` is unchanged.
- Abandon: client 0 changes address during WAIT. Rdy arrives → `cl_ok[0]` stays 0 and `cl_dout[0]` is unchanged. The new address is re-issued in the next arbitration.
- Same-cycle `ba_ack` and `ba_rdy` with DW=32 and `sdram_dout`=0xCAFEF00D. Expect `cl_dout[g]`=0xCAFEF00D, `cl_ok[g]` high the next cycle, and no WAIT state entered.
- Assert `rst` during REQ. All outputs must read 0 immediately, without waiting for a clock. After release, the FSM is IDLE and the first grant goes to client 0.
